// File: rtl/debug_baud_ctrl.sv
// Debug auto-baud sequencer and owner of the debug UART baud-rate register.
// Optional break re-arm in LOCKED is enabled by defining DEBUG_BAUD_BREAK_REARM_EN.
module debug_baud_ctrl #(
   parameter int TIMEOUT_W = 20,
   parameter int ARM_CYC   = 4,
   parameter int MIN_DIV   = 2,
   parameter int BRK_SHIFT = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   output logic       ab_rst_n,
   input  logic       ab_wr,
   input  logic [7:0] ab_div,
   input  logic [1:0] ab_rx_sel,
   input  logic       rx,
   input  logic       host_wr,
   input  logic [7:0] host_div,
   input  logic [1:0] host_sel,
   output logic       baud_wr,
   output logic [7:0] baud_div,
   output logic [1:0] rx_sel,
   output logic       locked,
   output logic       timeout_err,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARM       = 3'd1,
      HUNT      = 3'd2,
      LOCK_WAIT = 3'd3,
      LOCKED    = 3'd4,
      MANUAL    = 3'd5
   } state_t;

   localparam int ARM_W = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
   localparam logic [ARM_W-1:0]     ARM_LAST  = ARM_W'(ARM_CYC - 1);
   localparam logic [TIMEOUT_W-1:0] TO_MAX    = {TIMEOUT_W{1'b1}};
   localparam logic [7:0]           MIN_DIV_V = 8'(MIN_DIV);

   state_t                state_reg, state_next;
   logic [ARM_W-1:0]      arm_cnt_reg, arm_cnt_next;
   logic [TIMEOUT_W-1:0]  to_cnt_reg, to_cnt_next, to_inc;
   logic [1:0]            sel_prev_reg, sel_prev_next;
   logic [7:0]            baud_div_reg, baud_div_next;
   logic [1:0]            rx_sel_reg, rx_sel_next;
   logic                  locked_reg, locked_next;
   logic                  baud_wr_reg, baud_wr_next;
   logic                  wr_pend_reg, wr_pend_next;
   logic                  timeout_reg, timeout_next;
   logic                  ab_rst_n_reg, ab_rst_n_next;
   logic                  commit;

   assign to_inc = to_cnt_reg + TIMEOUT_W'(1);

`ifdef DEBUG_BAUD_BREAK_REARM_EN
   localparam int BRK_W = 8 + BRK_SHIFT;
   logic [BRK_W-1:0] brk_cnt_reg, brk_cnt_next, brk_inc, brk_lim;

   assign brk_inc = (&brk_cnt_reg) ? brk_cnt_reg : brk_cnt_reg + BRK_W'(1);
   assign brk_lim = BRK_W'(baud_div_reg) << BRK_SHIFT;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) brk_cnt_reg <= '0;
      else     brk_cnt_reg <= brk_cnt_next;
   end
`else
   logic [32:0] unused_brk;
   assign unused_brk = {rx, 32'(BRK_SHIFT)};
`endif

   always_comb begin
      state_next    = state_reg;
      arm_cnt_next  = '0;
      to_cnt_next   = '0;
      sel_prev_next = '0;
      baud_div_next = baud_div_reg;
      rx_sel_next   = rx_sel_reg;
      locked_next   = locked_reg;
      timeout_next  = 1'b0;
      commit        = 1'b0;
`ifdef DEBUG_BAUD_BREAK_REARM_EN
      brk_cnt_next  = '0;
`endif
      if (!enable) begin
         state_next  = IDLE;
         locked_next = 1'b0;
         rx_sel_next = 2'd0;
      end else if (host_wr && state_reg != IDLE) begin
         // Host override beats any detector strobe or timeout in the same cycle
         if (host_div != 8'd0) begin
            baud_div_next = host_div;
            rx_sel_next   = host_sel;
            locked_next   = 1'b1;
            commit        = 1'b1;
            state_next    = MANUAL;
         end else begin
            locked_next = 1'b0;
            rx_sel_next = 2'd0;
            state_next  = ARM;
         end
      end else begin
         case (state_reg)
            IDLE: state_next = ARM;
            ARM: begin
               if (arm_cnt_reg == ARM_LAST) state_next = HUNT;
               else                         arm_cnt_next = arm_cnt_reg + ARM_W'(1);
            end
            HUNT: begin
               to_cnt_next = to_inc;
               if (ab_wr) begin
                  to_cnt_next = '0;
                  if (ab_div >= MIN_DIV_V) begin
                     baud_div_next = ab_div;
                     commit        = 1'b1;
                     state_next    = LOCK_WAIT;
                  end else begin
                     state_next = ARM;
                  end
               end else if (to_inc == TO_MAX) begin
                  timeout_next = 1'b1;
                  state_next   = ARM;
               end
            end
            LOCK_WAIT: begin
               to_cnt_next   = to_inc;
               sel_prev_next = ab_rx_sel;
               // Previous sample is forced to zero outside this state, so a match means two real cycles
               if (ab_rx_sel != 2'd0 && ab_rx_sel == sel_prev_reg) begin
                  rx_sel_next = ab_rx_sel;
                  locked_next = 1'b1;
                  state_next  = LOCKED;
               end else if (to_inc == TO_MAX) begin
                  timeout_next = 1'b1;
                  state_next   = ARM;
               end
            end
            LOCKED: begin
`ifdef DEBUG_BAUD_BREAK_REARM_EN
               if (!rx) begin
                  brk_cnt_next = brk_inc;
                  if (brk_inc == brk_lim) begin
                     locked_next = 1'b0;
                     rx_sel_next = 2'd0;
                     state_next  = ARM;
                  end
               end
`endif
            end
            MANUAL: ;
            default: state_next = IDLE;
         endcase
      end

      // A commit landing on an active strobe is deferred one cycle; baud_div already holds the newest value
      baud_wr_next  = (commit | wr_pend_reg) & ~baud_wr_reg;
      wr_pend_next  = (commit | wr_pend_reg) & baud_wr_reg;
      ab_rst_n_next = (state_next == HUNT) || (state_next == LOCK_WAIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         arm_cnt_reg  <= '0;
         to_cnt_reg   <= '0;
         sel_prev_reg <= '0;
         baud_div_reg <= '0;
         rx_sel_reg   <= '0;
         locked_reg   <= 1'b0;
         baud_wr_reg  <= 1'b0;
         wr_pend_reg  <= 1'b0;
         timeout_reg  <= 1'b0;
         ab_rst_n_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         arm_cnt_reg  <= arm_cnt_next;
         to_cnt_reg   <= to_cnt_next;
         sel_prev_reg <= sel_prev_next;
         baud_div_reg <= baud_div_next;
         rx_sel_reg   <= rx_sel_next;
         locked_reg   <= locked_next;
         baud_wr_reg  <= baud_wr_next;
         wr_pend_reg  <= wr_pend_next;
         timeout_reg  <= timeout_next;
         ab_rst_n_reg <= ab_rst_n_next;
      end
   end

   assign ab_rst_n    = ab_rst_n_reg;
   assign baud_wr     = baud_wr_reg;
   assign baud_div    = baud_div_reg;
   assign rx_sel      = rx_sel_reg;
   assign locked      = locked_reg;
   assign timeout_err = timeout_reg;
   assign state_o     = state_reg;

endmodule

// File: tb/tb_debug_baud_ctrl.sv
// Directed bench for debug_baud_ctrl, built with TIMEOUT_W=6 so timeouts take 63 cycles.
// Break re-arm expectations follow DEBUG_BAUD_BREAK_REARM_EN.
module tb_debug_baud_ctrl;
   logic       clk = 1'b0;
   logic       rst, enable, ab_wr, rx, host_wr;
   logic [7:0] ab_div, host_div;
   logic [1:0] ab_rx_sel, host_sel;
   logic       ab_rst_n, baud_wr, locked, timeout_err;
   logic [7:0] baud_div;
   logic [1:0] rx_sel;
   logic [2:0] state_o;
   int         tests_run = 0;
   int         tests_failed = 0;

   always #5 clk = ~clk;

   debug_baud_ctrl #(.TIMEOUT_W(6), .ARM_CYC(4), .MIN_DIV(2), .BRK_SHIFT(9)) dut (
      .clk(clk), .rst(rst), .enable(enable), .ab_rst_n(ab_rst_n),
      .ab_wr(ab_wr), .ab_div(ab_div), .ab_rx_sel(ab_rx_sel), .rx(rx),
      .host_wr(host_wr), .host_div(host_div), .host_sel(host_sel),
      .baud_wr(baud_wr), .baud_div(baud_div), .rx_sel(rx_sel), .locked(locked),
      .timeout_err(timeout_err), .state_o(state_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n = ticks until state_o==target, or -1 if the budget expires
   task automatic wait_state(input logic [2:0] target, input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (state_o !== target && n < max);
      if (state_o !== target) n = -1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; ab_wr = 1'b0; ab_div = 8'h00; ab_rx_sel = 2'd0;
      rx = 1'b1; host_wr = 1'b0; host_div = 8'h00; host_sel = 2'd0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      tests_run++;
      if ({ab_rst_n, baud_wr, baud_div, rx_sel, locked, timeout_err, state_o} !== 17'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h expected 00000",
                  {ab_rst_n, baud_wr, baud_div, rx_sel, locked, timeout_err, state_o});
      end
      do_reset();
      tick();
      tests_run++;
      if ({state_o, ab_rst_n} !== {3'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_idle_hold: got state %0d ab_rst_n %b expected 0 0", state_o, ab_rst_n);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_lock();
      int n;
      do_reset();
      enable = 1'b1;
      wait_state(3'd2, 20, n);
      tests_run++;
      if (n !== 5 || ab_rst_n !== 1'b1) begin
         tests_failed++;
         $display("FAIL lock_hunt_entry: got %0d ticks ab_rst_n %b expected 5 ticks ab_rst_n 1", n, ab_rst_n);
      end
      repeat (14) tick();
      ab_wr = 1'b1; ab_div = 8'h1A;
      tick();
      ab_wr = 1'b0;
      tests_run++;
      if ({state_o, baud_wr, baud_div, ab_rst_n} !== {3'd3, 1'b1, 8'h1A, 1'b1}) begin
         tests_failed++;
         $display("FAIL lock_commit: got state %0d wr %b div %h expected 3 1 1a", state_o, baud_wr, baud_div);
      end
      tick();
      tests_run++;
      if (baud_wr !== 1'b0) begin
         tests_failed++;
         $display("FAIL lock_wr_single: got baud_wr %b expected 0", baud_wr);
      end
      ab_rx_sel = 2'd2;
      tick();
      tests_run++;
      if (state_o !== 3'd3) begin
         tests_failed++;
         $display("FAIL lock_one_sample: got state %0d expected 3", state_o);
      end
      tick();
      ab_rx_sel = 2'd0;
      tests_run++;
      if ({state_o, locked, rx_sel, ab_rst_n} !== {3'd4, 1'b1, 2'd2, 1'b0}) begin
         tests_failed++;
         $display("FAIL lock_locked: got state %0d locked %b sel %0d ab_rst_n %b expected 4 1 2 0",
                  state_o, locked, rx_sel, ab_rst_n);
      end
      $display("[TB] test_lock done");
   endtask

   task automatic test_reject();
      int n;
      do_reset();
      enable = 1'b1;
      wait_state(3'd2, 20, n);
      ab_wr = 1'b1; ab_div = 8'h01;
      tick();
      ab_wr = 1'b0;
      tests_run++;
      if ({state_o, baud_wr, ab_rst_n, baud_div} !== {3'd1, 1'b0, 1'b0, 8'h00}) begin
         tests_failed++;
         $display("FAIL reject_small: got state %0d wr %b ab_rst_n %b div %h expected 1 0 0 00",
                  state_o, baud_wr, ab_rst_n, baud_div);
      end
      wait_state(3'd2, 10, n);
      tests_run++;
      if (n !== 4 || ab_rst_n !== 1'b1) begin
         tests_failed++;
         $display("FAIL reject_arm_len: got %0d ticks ab_rst_n %b expected 4 ticks ab_rst_n 1", n, ab_rst_n);
      end
      ab_wr = 1'b1; ab_div = 8'h02;
      tick();
      ab_wr = 1'b0;
      tests_run++;
      if ({state_o, baud_wr, baud_div} !== {3'd3, 1'b1, 8'h02}) begin
         tests_failed++;
         $display("FAIL reject_min_ok: got state %0d wr %b div %h expected 3 1 02", state_o, baud_wr, baud_div);
      end
      $display("[TB] test_reject done");
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      enable = 1'b1;
      wait_state(3'd2, 20, n);
      wait_state(3'd1, 100, n);
      tests_run++;
      if (n !== 63 || timeout_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_hunt: got %0d ticks err %b expected 63 ticks err 1", n, timeout_err);
      end
      tick();
      tests_run++;
      if (timeout_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_pulse: got err %b expected 0", timeout_err);
      end
      wait_state(3'd2, 10, n);
      wait_state(3'd1, 100, n);
      tests_run++;
      if (n !== 63 || timeout_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_repeat: got %0d ticks err %b expected 63 ticks err 1", n, timeout_err);
      end
      wait_state(3'd2, 10, n);
      ab_wr = 1'b1; ab_div = 8'h09;
      tick();
      ab_wr = 1'b0;
      wait_state(3'd1, 100, n);
      tests_run++;
      if (n !== 63 || timeout_err !== 1'b1 || baud_div !== 8'h09) begin
         tests_failed++;
         $display("FAIL timeout_lockwait: got %0d ticks err %b div %h expected 63 1 09", n, timeout_err, baud_div);
      end
      $display("[TB] test_timeout done");
   endtask

   task automatic test_host();
      int n;
      do_reset();
      enable = 1'b1;
      wait_state(3'd2, 20, n);
      host_wr = 1'b1; host_div = 8'h40; host_sel = 2'd3;
      ab_wr = 1'b1; ab_div = 8'h1A;
      tick();
      host_wr = 1'b0; ab_wr = 1'b0;
      tests_run++;
      if ({state_o, baud_wr, baud_div, rx_sel, locked} !== {3'd5, 1'b1, 8'h40, 2'd3, 1'b1}) begin
         tests_failed++;
         $display("FAIL host_override: got state %0d wr %b div %h sel %0d locked %b expected 5 1 40 3 1",
                  state_o, baud_wr, baud_div, rx_sel, locked);
      end
      tick();
      tests_run++;
      if ({state_o, baud_wr} !== {3'd5, 1'b0}) begin
         tests_failed++;
         $display("FAIL host_single_wr: got state %0d wr %b expected 5 0", state_o, baud_wr);
      end
      ab_wr = 1'b1; ab_div = 8'h20;
      tick();
      ab_wr = 1'b0;
      tests_run++;
      if ({state_o, baud_div, baud_wr} !== {3'd5, 8'h40, 1'b0}) begin
         tests_failed++;
         $display("FAIL host_manual_ab: got state %0d div %h wr %b expected 5 40 0", state_o, baud_div, baud_wr);
      end
      host_wr = 1'b1; host_div = 8'h00;
      tick();
      host_wr = 1'b0;
      tests_run++;
      if ({state_o, locked, baud_wr, ab_rst_n} !== {3'd1, 1'b0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL host_rerun: got state %0d locked %b wr %b expected 1 0 0", state_o, locked, baud_wr);
      end
      $display("[TB] test_host done");
   endtask

   task automatic test_back_to_back();
      do_reset();
      enable = 1'b1;
      host_wr = 1'b1; host_div = 8'h77; host_sel = 2'd2;
      tick();
      host_wr = 1'b0;
      tests_run++;
      if ({state_o, baud_div, baud_wr} !== {3'd1, 8'h00, 1'b0}) begin
         tests_failed++;
         $display("FAIL idle_host_ignored: got state %0d div %h wr %b expected 1 00 0", state_o, baud_div, baud_wr);
      end
      host_wr = 1'b1; host_div = 8'h10; host_sel = 2'd1;
      tick();
      tests_run++;
      if ({state_o, baud_wr, baud_div} !== {3'd5, 1'b1, 8'h10}) begin
         tests_failed++;
         $display("FAIL b2b_first: got state %0d wr %b div %h expected 5 1 10", state_o, baud_wr, baud_div);
      end
      host_div = 8'h11;
      tick();
      host_wr = 1'b0;
      tests_run++;
      if ({baud_wr, baud_div} !== {1'b0, 8'h11}) begin
         tests_failed++;
         $display("FAIL b2b_gap: got wr %b div %h expected 0 11", baud_wr, baud_div);
      end
      tick();
      tests_run++;
      if ({baud_wr, baud_div} !== {1'b1, 8'h11}) begin
         tests_failed++;
         $display("FAIL b2b_second: got wr %b div %h expected 1 11", baud_wr, baud_div);
      end
      tick();
      tests_run++;
      if (baud_wr !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_end: got wr %b expected 0", baud_wr);
      end
      $display("[TB] test_back_to_back done");
   endtask

   task automatic test_break();
      int n;
      logic [4:0] exp_end;
`ifdef DEBUG_BAUD_BREAK_REARM_EN
      exp_end = {3'd1, 1'b0, 1'b0};
`else
      exp_end = {3'd4, 1'b1, 1'b1};
`endif
      do_reset();
      enable = 1'b1;
      wait_state(3'd2, 20, n);
      ab_wr = 1'b1; ab_div = 8'h04;
      tick();
      ab_wr = 1'b0; ab_rx_sel = 2'd1;
      tick(); tick();
      ab_rx_sel = 2'd0;
      rx = 1'b0;
      repeat (2047) tick();
      rx = 1'b1;
      tick();
      tests_run++;
      if ({state_o, locked} !== {3'd4, 1'b1}) begin
         tests_failed++;
         $display("FAIL break_short: got state %0d locked %b expected 4 1", state_o, locked);
      end
      rx = 1'b0;
      repeat (2047) tick();
      tests_run++;
      if (state_o !== 3'd4) begin
         tests_failed++;
         $display("FAIL break_edge: got state %0d expected 4", state_o);
      end
      tick();
      rx = 1'b1;
      tests_run++;
      if ({state_o, locked, rx_sel[0]} !== exp_end) begin
         tests_failed++;
         $display("FAIL break_full: got %b expected %b", {state_o, locked, rx_sel[0]}, exp_end);
      end
      $display("[TB] test_break done");
   endtask

   task automatic test_async_reset();
      int n;
      do_reset();
      enable = 1'b1;
      wait_state(3'd2, 20, n);
      repeat (3) tick();
      rst = 1'b1;
      #2;
      tests_run++;
      if ({ab_rst_n, baud_wr, baud_div, rx_sel, locked, timeout_err, state_o} !== 17'h0) begin
         tests_failed++;
         $display("FAIL rst_mid_hunt: got %h expected 00000",
                  {ab_rst_n, baud_wr, baud_div, rx_sel, locked, timeout_err, state_o});
      end
      do_reset();
      enable = 1'b1;
      wait_state(3'd2, 20, n);
      ab_wr = 1'b1; ab_div = 8'h33;
      tick();
      ab_wr = 1'b0;
      tests_run++;
      if (baud_wr !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_pre_wr: got wr %b expected 1", baud_wr);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if ({ab_rst_n, baud_wr, baud_div, rx_sel, locked, timeout_err, state_o} !== 17'h0) begin
         tests_failed++;
         $display("FAIL rst_during_wr: got %h expected 00000",
                  {ab_rst_n, baud_wr, baud_div, rx_sel, locked, timeout_err, state_o});
      end
      do_reset();
      enable = 1'b1;
      tick();
      host_wr = 1'b1; host_div = 8'h55; host_sel = 2'd1;
      tick();
      host_wr = 1'b0;
      enable = 1'b0;
      tick();
      tests_run++;
      if ({state_o, locked, rx_sel, baud_div, ab_rst_n} !== {3'd0, 1'b0, 2'd0, 8'h55, 1'b0}) begin
         tests_failed++;
         $display("FAIL disable_idle: got state %0d locked %b sel %0d div %h expected 0 0 0 55",
                  state_o, locked, rx_sel, baud_div);
      end
      $display("[TB] test_async_reset done");
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; ab_wr = 1'b0; ab_div = 8'h00; ab_rx_sel = 2'd0;
      rx = 1'b1; host_wr = 1'b0; host_div = 8'h00; host_sel = 2'd0;
      test_reset();
      test_lock();
      test_reject();
      test_timeout();
      test_host();
      test_back_to_back();
      test_break();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
